alu_wb_sequencer: RTL and testbench

- Execute/write-back stage directly downstream of the 8x16 register file.
- Accepts one micro-instruction per handshake, drives the two register-file read addresses, and latches both operands.
- Performs one ALU or serial-shift operation, then writes the result back through the register-file write port.
- Shifts run one bit per cycle, reusing the shift-register style of the datapath.

---
 rtl/alu_wb_sequencer_pkg.sv | 27 ++
 rtl/alu_wb_sequencer_serial_shifter.sv | 34 +++
 rtl/alu_wb_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_wb_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_sequencer_pkg.sv
// Shared definitions for the ALU write-back sequencer: op encodings, FSM states, default widths.
package alu_wb_sequencer_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AW_DEF    = 3;
    localparam int SHW_DEF   = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_MOVA = 3'b111;
    // Same encoding as MOVA; reinterpreted when arithmetic shift is built in.
    localparam logic [2:0] OP_ASR  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_SHIFT,
        S_WB
    } state_t;

endpackage

// File: rtl/alu_wb_sequencer_serial_shifter.sv
// One-bit-per-cycle shift register with selectable direction and fill bit.
module serial_shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             right,
    input  logic             fill,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= q_next;
        end
    end

    // q_next/out_bit describe the coming shift so the caller can commit the final value on the same edge.
    always_comb begin
        q_next  = right ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
        out_bit = right ? q[0] : q[WIDTH-1];
    end

endmodule

// File: rtl/alu_wb_sequencer.sv
// Execute/write-back sequencer: read operands, run one ALU or serial-shift op, write the result back.
// Build option ALU_WB_ASR_EN turns op 111 from MOVA into arithmetic shift right.
module alu_wb_sequencer
    import alu_wb_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    rs_a,
    input  logic [AW-1:0]    rs_b,
    input  logic [AW-1:0]    rd,
    input  logic [SHW-1:0]   shamt,
    output logic [AW-1:0]    rd_addr_a,
    output logic [AW-1:0]    rd_addr_b,
    input  logic [WIDTH-1:0] d_out_a,
    input  logic [WIDTH-1:0] d_out_b,
    output logic             wr,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    state_t           state;
    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [SHW-1:0]   shamt_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             shift_op;
    logic             sh_fill;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic             fin_go;
    logic [WIDTH-1:0] fin_r;
    logic             fin_c;

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);

`ifdef ALU_WB_ASR_EN
    assign shift_op = (op_q == OP_SHL) || (op_q == OP_SHR) || (op_q == OP_ASR);
    // Operand A stays latched during the shift, so its MSB is the sign to replicate.
    assign sh_fill  = (op_q == OP_ASR) & op_a[WIDTH-1];
`else
    assign shift_op = (op_q == OP_SHL) || (op_q == OP_SHR);
    assign sh_fill  = 1'b0;
`endif

    serial_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (state == S_EXEC),
        .shift     (state == S_SHIFT),
        .right     (op_q != OP_SHL),
        .fill      (sh_fill),
        .load_data (op_a),
        .q_next    (sh_next),
        .out_bit   (sh_out)
    );

    always_comb begin
        alu_r = op_a;
        alu_c = 1'b0;
        case (op_q)
            OP_ADD: {alu_c, alu_r} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB: begin
                alu_r = op_a - op_b;
                alu_c = (op_a < op_b);
            end
            OP_AND: alu_r = op_a & op_b;
            OP_OR:  alu_r = op_a | op_b;
            OP_XOR: alu_r = op_a ^ op_b;
            default: ;
        endcase
    end

    // Result and flags committed on the edge that enters WB.
    always_comb begin
        fin_go = 1'b0;
        fin_r  = alu_r;
        fin_c  = alu_c;
        if (state == S_EXEC) begin
            if (shift_op) begin
                fin_r  = op_a;
                fin_c  = 1'b0;
                fin_go = (shamt_q == '0);
            end else begin
                fin_go = 1'b1;
            end
        end else if (state == S_SHIFT) begin
            fin_r  = sh_next;
            fin_c  = sh_out;
            fin_go = (cnt == SHW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            rd_q      <= '0;
            shamt_q   <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            wr        <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else begin
            wr <= 1'b0;
            case (state)
                S_IDLE: if (instr_valid) begin
                    op_q      <= op;
                    rd_addr_a <= rs_a;
                    rd_addr_b <= rs_b;
                    rd_q      <= rd;
                    shamt_q   <= shamt;
                    state     <= S_READ;
                end
                S_READ: begin
                    op_a  <= d_out_a;
                    op_b  <= d_out_b;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    cnt <= shamt_q;
                    if (!fin_go) state <= S_SHIFT;
                end
                S_SHIFT: cnt <= cnt - SHW'(1);
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (fin_go) begin
                wr      <= 1'b1;
                wr_addr <= rd_q;
                wr_data <= fin_r;
                carry   <= fin_c;
                zero    <= (fin_r == '0);
                state   <= S_WB;
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_sequencer.sv
// Directed bench for alu_wb_sequencer with a behavioural 8x16 register file.
module tb_alu_wb_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic [2:0]  rs_a, rs_b, rd;
    logic [3:0]  shamt;
    logic [2:0]  rd_addr_a, rd_addr_b;
    logic [15:0] d_out_a, d_out_b;
    logic        wr;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        carry, zero, busy;

    logic [15:0] regs [8];
    int          wr_count = 0;
    int          checks = 0;
    int          fails = 0;

    int          got_lat, got_span, got_pulses;
    logic [2:0]  got_addr;
    logic [15:0] got_data;
    logic        got_c, got_z;

    always #5 clk = ~clk;

    alu_wb_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .rd          (rd),
        .shamt       (shamt),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .d_out_a     (d_out_a),
        .d_out_b     (d_out_b),
        .wr          (wr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .carry       (carry),
        .zero        (zero),
        .busy        (busy)
    );

    assign d_out_a = regs[rd_addr_a];
    assign d_out_b = regs[rd_addr_b];

    always @(posedge clk) begin
        if (wr) begin
            regs[wr_addr] = wr_data;
            wr_count = wr_count + 1;
        end
    end

    // Issue one instruction from IDLE and capture the write-back it produces.
    task automatic run_op(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] d, input logic [3:0] s);
        int start;
        bit found;
        start = wr_count;
        @(negedge clk);
        instr_valid = 1'b1;
        op = o; rs_a = a; rs_b = b; rd = d; shamt = s;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        got_lat = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            got_lat++;
            if (wr) begin
                found = 1'b1;
                got_addr = wr_addr; got_data = wr_data; got_c = carry; got_z = zero;
            end
        end
        if (!found) begin
            checks++; fails++;
            $display("FAIL wr_timeout: no write within 40 cycles for op %0d", o);
            got_lat = -1;
        end
        got_span = got_lat;
        for (int i = 0; i < 40 && !instr_ready; i++) begin
            @(negedge clk);
            got_span++;
        end
        got_pulses = wr_count - start;
    endtask

    task automatic test_reset;
        reset = 1'b1; instr_valid = 1'b0;
        op = 3'b000; rs_a = 3'd0; rs_b = 3'd0; rd = 3'd0; shamt = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b want 0", wr); end
        checks++; if (wr_data !== 16'h0000) begin fails++; $display("FAIL reset_wr_data: got %h want 0000", wr_data); end
        checks++; if (rd_addr_a !== 3'd0 || rd_addr_b !== 3'd0) begin fails++; $display("FAIL reset_rd_addr: got %0d/%0d want 0/0", rd_addr_a, rd_addr_b); end
        checks++; if ({carry, zero} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {carry, zero}); end
        checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_ready: ready %b busy %b want 1 0", instr_ready, busy); end
    endtask

    task automatic test_add;
        @(negedge clk);
        regs[1] = 16'hFFFF; regs[2] = 16'h0001;
        run_op(3'b000, 3'd1, 3'd2, 3'd3, 4'd0);
        checks++; if (got_lat !== 3) begin fails++; $display("FAIL add_latency: got %0d want 3", got_lat); end
        checks++; if (got_addr !== 3'd3) begin fails++; $display("FAIL add_addr: got %0d want 3", got_addr); end
        checks++; if (got_data !== 16'h0000) begin fails++; $display("FAIL add_data: got %h want 0000", got_data); end
        checks++; if ({got_c, got_z} !== 2'b11) begin fails++; $display("FAIL add_flags: got %b want 11", {got_c, got_z}); end
        checks++; if (got_span !== 4) begin fails++; $display("FAIL add_span: got %0d want 4", got_span); end
        checks++; if (got_pulses !== 1) begin fails++; $display("FAIL add_pulses: got %0d want 1", got_pulses); end
    endtask

    task automatic test_reset_mid_shift;
        int start;
        @(negedge clk);
        regs[4] = 16'h8001; regs[7] = 16'h1234;
        start = wr_count;
        instr_valid = 1'b1;
        op = 3'b101; rs_a = 3'd4; rs_b = 3'd0; rd = 3'd7; shamt = 4'd8;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (wr !== 1'b0) begin fails++; $display("FAIL rst_mid_wr: got %b want 0", wr); end
        checks++; if ({carry, zero} !== 2'b00) begin fails++; $display("FAIL rst_mid_flags: got %b want 00", {carry, zero}); end
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", instr_ready); end
        repeat (12) @(negedge clk);
        checks++; if (wr_count - start !== 0) begin fails++; $display("FAIL rst_mid_no_write: got %0d writes want 0", wr_count - start); end
        checks++; if (regs[7] !== 16'h1234) begin fails++; $display("FAIL rst_mid_r7: got %h want 1234", regs[7]); end
    endtask

    task automatic test_sub_mova;
        @(negedge clk);
        regs[1] = 16'h0003; regs[2] = 16'h0005;
        run_op(3'b001, 3'd1, 3'd2, 3'd1, 4'd0);
        checks++; if (got_addr !== 3'd1 || got_data !== 16'hFFFE) begin fails++; $display("FAIL sub_result: got r%0d=%h want r1=fffe", got_addr, got_data); end
        checks++; if ({got_c, got_z} !== 2'b10) begin fails++; $display("FAIL sub_flags: got %b want 10", {got_c, got_z}); end
        run_op(3'b111, 3'd1, 3'd2, 3'd6, 4'd0);
        checks++; if (got_data !== 16'hFFFE || got_addr !== 3'd6) begin fails++; $display("FAIL mova_result: got r%0d=%h want r6=fffe", got_addr, got_data); end
        checks++; if ({got_c, got_z} !== 2'b00 || got_lat !== 3) begin fails++; $display("FAIL mova_flags_lat: got %b lat %0d want 00 lat 3", {got_c, got_z}, got_lat); end
    endtask

    task automatic test_shifts;
        @(negedge clk);
        regs[4] = 16'h8001;
        run_op(3'b101, 3'd4, 3'd0, 3'd2, 4'd1);
        checks++; if (got_data !== 16'h0002 || got_c !== 1'b1) begin fails++; $display("FAIL shl1_result: got %h c%b want 0002 c1", got_data, got_c); end
        checks++; if (got_lat !== 4 || got_span !== 5) begin fails++; $display("FAIL shl1_timing: got lat %0d span %0d want 4 5", got_lat, got_span); end
        run_op(3'b110, 3'd4, 3'd0, 3'd2, 4'd4);
        checks++; if (got_data !== 16'h0800 || got_c !== 1'b0) begin fails++; $display("FAIL shr4_result: got %h c%b want 0800 c0", got_data, got_c); end
        checks++; if (got_lat !== 7 || got_pulses !== 1) begin fails++; $display("FAIL shr4_timing: got lat %0d pulses %0d want 7 1", got_lat, got_pulses); end
        run_op(3'b101, 3'd4, 3'd0, 3'd2, 4'd0);
        checks++; if (got_data !== 16'h8001 || got_c !== 1'b0 || got_lat !== 3) begin fails++; $display("FAIL shl0_result: got %h c%b lat %0d want 8001 c0 lat 3", got_data, got_c, got_lat); end
    endtask

    task automatic test_op111;
        logic [15:0] exp_data;
        int          exp_lat;
`ifdef ALU_WB_ASR_EN
        exp_data = 16'hF000; exp_lat = 6;
`else
        exp_data = 16'h8000; exp_lat = 3;
`endif
        @(negedge clk);
        regs[5] = 16'h8000;
        run_op(3'b111, 3'd5, 3'd0, 3'd7, 4'd3);
        checks++; if (got_data !== exp_data || got_c !== 1'b0) begin fails++; $display("FAIL op111_result: got %h c%b want %h c0", got_data, got_c, exp_data); end
        checks++; if (got_lat !== exp_lat) begin fails++; $display("FAIL op111_latency: got %0d want %0d", got_lat, exp_lat); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] ops [3];
        int start, waited;
        ops[0] = 3'b100; ops[1] = 3'b010; ops[2] = 3'b011;
        @(negedge clk);
        regs[2] = 16'h0F0F; regs[3] = 16'h00FF;
        start = wr_count;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; rs_a = 3'd2; rs_b = 3'd3; rd = 3'(4 + k); shamt = 4'd0;
            waited = 0;
            while (!instr_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (k > 0) begin
                checks++; if (waited + 1 !== 4) begin fails++; $display("FAIL b2b_spacing%0d: got %0d want 4", k, waited + 1); end
            end
            @(posedge clk);
            if (k == 2) #1 instr_valid = 1'b0;
            else @(negedge clk);
        end
        repeat (6) @(negedge clk);
        checks++; if (wr_count - start !== 3) begin fails++; $display("FAIL b2b_pulses: got %0d want 3", wr_count - start); end
        checks++; if (regs[4] !== 16'h0FF0) begin fails++; $display("FAIL b2b_xor: got %h want 0ff0", regs[4]); end
        checks++; if (regs[5] !== 16'h000F) begin fails++; $display("FAIL b2b_and: got %h want 000f", regs[5]); end
        checks++; if (regs[6] !== 16'h0FFF) begin fails++; $display("FAIL b2b_or: got %h want 0fff", regs[6]); end
        checks++; if ({carry, zero} !== 2'b00) begin fails++; $display("FAIL b2b_flags: got %b want 00", {carry, zero}); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        test_reset;
        test_add;
        test_reset_mid_shift;
        test_sub_mova;
        test_shifts;
        test_op111;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
